// File: rtl/nonstall_drain_fifo.sv
// Credit-controlled receive buffer behind a fixed-latency, non-stallable pipeline.
// Reserves a slot per injected beat and drains stored beats in order over valid/ready.
module nonstall_drain_fifo #(
    parameter int unsigned WIDTH    = 100,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned PIPE_LAT = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic                         up_allow,
    input  logic                         up_issue,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         err
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = $clog2(DEPTH + PIPE_LAT + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SW = IW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, rd_ptr_nxt;
    logic [PW-1:0]    wr_ptr, wr_ptr_nxt;
    logic [CW-1:0]    count_nxt;
    logic [IW-1:0]    inflight, inflight_nxt;
    logic             err_nxt;
    logic             full;
    logic             push;
    logic             pop;
    logic [SW-1:0]    reserved;

    // Outputs decoded straight from registered state
    assign reserved  = SW'(count) + SW'(inflight);
    assign up_allow  = (reserved < SW'(DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    assign full = (count == CW'(DEPTH));
    assign pop  = out_valid & out_ready;
    // A beat arriving into a full buffer is only kept if the head leaves this cycle
    assign push = in_valid & (~full | pop);

    // Next-state for pointers, occupancy, credit and error flag
    always_comb begin
        rd_ptr_nxt   = rd_ptr;
        wr_ptr_nxt   = wr_ptr;
        count_nxt    = count;
        inflight_nxt = inflight;
        err_nxt      = err;

        if (pop) begin
            rd_ptr_nxt = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
        end
        if (push) begin
            wr_ptr_nxt = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase

        // Saturate so a protocol violation cannot wrap the credit counter
        case ({up_issue, in_valid})
            2'b10: begin
                if (inflight != {IW{1'b1}}) inflight_nxt = inflight + IW'(1);
            end
            2'b01: begin
                if (inflight != '0) inflight_nxt = inflight - IW'(1);
            end
            default: inflight_nxt = inflight;
        endcase

        if ((up_issue & ~up_allow) |
            (in_valid & (inflight == '0)) |
            (in_valid & full & ~pop)) begin
            err_nxt = 1'b1;
        end
    end

    // Control state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            err      <= 1'b0;
        end else begin
            rd_ptr   <= rd_ptr_nxt;
            wr_ptr   <= wr_ptr_nxt;
            count    <= count_nxt;
            inflight <= inflight_nxt;
            err      <= err_nxt;
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_nonstall_drain_fifo.sv
// Self-checking bench: directed vector table, hand sequences for corner cases,
// and randomized traffic through a modelled fixed-latency pipeline against a queue model.
module tb_nonstall_drain_fifo;

    localparam int unsigned WIDTH    = 100;
    localparam int unsigned DEPTH    = 8;
    localparam int unsigned PIPE_LAT = 3;
    localparam int unsigned CW       = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_n;
    logic             up_allow;
    logic             up_issue;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;
    logic             err;

    nonstall_drain_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PIPE_LAT(PIPE_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .up_allow  (up_allow),
        .up_issue  (up_issue),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int popped = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] rnd();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[WIDTH-1:0];
    endfunction

    // Reference model: stored beats as a queue, the pipeline as a fixed-length delay line
    typedef struct {
        logic             v;
        logic [WIDTH-1:0] d;
    } beat_t;

    logic [WIDTH-1:0] mq[$];
    beat_t            pipe[$];
    logic             m_err;

    function automatic int pipe_occ();
        int n;
        n = 0;
        foreach (pipe[i]) if (pipe[i].v) n++;
        return n;
    endfunction

    task automatic model_reset();
        beat_t e;
        e.v = 1'b0;
        e.d = '0;
        mq.delete();
        pipe.delete();
        for (int i = 0; i < PIPE_LAT; i++) pipe.push_back(e);
        m_err  = 1'b0;
        popped = 0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " count"}, count, mq.size());
        chk({tag, " up_allow"}, up_allow, (mq.size() + pipe_occ()) < DEPTH);
        chk({tag, " out_valid"}, out_valid, mq.size() != 0);
        chk({tag, " out_data"}, out_data, (mq.size() != 0) ? mq[0] : '0);
        chk({tag, " err"}, err, m_err);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        up_issue  = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock of traffic: issue into the modelled pipeline, deliver its oldest stage,
    // optionally inject an unsolicited beat, then compare every output with the model.
    task automatic cycle(input bit issue_req, input bit gate, input bit inject, input bit rdy,
                         input logic [WIDTH-1:0] d_issue, input logic [WIDTH-1:0] d_inj,
                         output bit issued);
        int    occ;
        bit    allow, pop, full;
        beat_t arr, nb;
        occ   = pipe_occ();
        allow = (mq.size() + occ) < DEPTH;
        arr   = pipe.pop_front();
        if (inject) begin
            arr.v = 1'b1;
            arr.d = d_inj;
        end
        nb.v = issue_req && (allow || !gate);
        nb.d = d_issue;
        pipe.push_back(nb);
        up_issue  = nb.v;
        in_valid  = arr.v;
        in_data   = arr.v ? arr.d : rnd();
        out_ready = rdy;
        pop  = (mq.size() != 0) && rdy;
        full = (mq.size() == DEPTH);
        if ((nb.v && !allow) || (arr.v && occ == 0) || (arr.v && full && !pop)) m_err = 1'b1;
        @(posedge clk);
        #1;
        if (pop) begin
            void'(mq.pop_front());
            popped++;
        end
        if (arr.v && (!full || pop)) mq.push_back(arr.d);
        check_model("cyc");
        issued = nb.v;
    endtask

    typedef struct {
        logic             issue;
        logic             inv;
        logic             rdy;
        logic [WIDTH-1:0] d;
        logic [CW-1:0]    e_cnt;
        logic             e_allow;
        logic             e_valid;
        logic             e_err;
        logic [WIDTH-1:0] e_data;
    } vec_t;

    function automatic vec_t mk(input logic issue, input logic inv, input logic rdy, input int d,
                                input int e_cnt, input logic e_valid, input logic e_err,
                                input int e_data);
        vec_t v;
        v.issue   = issue;
        v.inv     = inv;
        v.rdy     = rdy;
        v.d       = WIDTH'(d);
        v.e_cnt   = CW'(e_cnt);
        v.e_allow = 1'b1;
        v.e_valid = e_valid;
        v.e_err   = e_err;
        v.e_data  = WIDTH'(e_data);
        return v;
    endfunction

    initial begin
        vec_t tbl[12];
        bit   got;
        int   issued;
        int   pct;

        // issue, in_valid, ready, data -> count, out_valid, err, out_data after the edge
        tbl[0]  = mk(1, 0, 0, 'hA0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 'hA1, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 'hA2, 0, 0, 0, 0);
        tbl[3]  = mk(1, 1, 0, 'hA3, 1, 1, 0, 'hA3);
        tbl[4]  = mk(0, 1, 0, 'hA4, 2, 1, 0, 'hA3);
        tbl[5]  = mk(0, 1, 0, 'hA5, 3, 1, 0, 'hA3);
        tbl[6]  = mk(0, 1, 1, 'hA6, 3, 1, 0, 'hA4);
        tbl[7]  = mk(0, 0, 1, 'hA7, 2, 1, 0, 'hA5);
        tbl[8]  = mk(0, 0, 1, 'hA8, 1, 1, 0, 'hA6);
        tbl[9]  = mk(0, 0, 1, 'hA9, 0, 0, 0, 0);
        tbl[10] = mk(0, 1, 0, 'hAA, 1, 1, 1, 'hAA);
        tbl[11] = mk(0, 0, 1, 'hAB, 0, 0, 1, 0);

        do_reset();
        #1;
        chk("t1 up_allow", up_allow, 1);
        chk("t1 out_valid", out_valid, 0);
        chk("t1 out_data", out_data, 0);
        chk("t1 count", count, 0);
        chk("t1 err", err, 0);

        for (int i = 0; i < 12; i++) begin
            up_issue  = tbl[i].issue;
            in_valid  = tbl[i].inv;
            in_data   = tbl[i].d;
            out_ready = tbl[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d count", i), count, tbl[i].e_cnt);
            chk($sformatf("vec%0d up_allow", i), up_allow, tbl[i].e_allow);
            chk($sformatf("vec%0d out_valid", i), out_valid, tbl[i].e_valid);
            chk($sformatf("vec%0d out_data", i), out_data, tbl[i].e_data);
            chk($sformatf("vec%0d err", i), err, tbl[i].e_err);
        end

        // Fill with consumer stalled
        do_reset();
        issued = 0;
        for (int c = 0; c < 20 && issued < 8; c++) begin
            cycle(1, 1, 0, 0, WIDTH'(issued), '0, got);
            if (got) issued++;
        end
        chk("t2 issued", issued, 8);
        chk("t2 allow_low", up_allow, 0);
        for (int c = 0; c < 20 && count != CW'(DEPTH); c++) cycle(0, 1, 0, 0, '0, '0, got);
        chk("t2 count_full", count, DEPTH);
        chk("t2 err", err, 0);

        // Push and pop together while full
        for (int k = 0; k < 4; k++) begin
            chk("t3 order", out_data, k);
            cycle(0, 1, 1, 1, '0, WIDTH'(8 + k), got);
            chk("t3 count", count, DEPTH);
        end
        for (int k = 4; k < 12; k++) begin
            chk("t2 drain order", out_data, k);
            cycle(0, 1, 0, 1, '0, '0, got);
        end
        chk("t2 count_empty", count, 0);
        chk("t2 allow_back", up_allow, 1);

        // Back-to-back streaming with a free-running consumer
        do_reset();
        for (int k = 0; k < 100; k++) begin
            chk("t4 allow", up_allow, 1);
            cycle(1, 1, 0, 1, WIDTH'(1000 + k), '0, got);
            if (k <= 3) chk("t4 first_valid", out_valid, k == 3);
        end
        for (int c = 0; c < 20 && (count != '0 || pipe_occ() != 0); c++) cycle(0, 1, 0, 1, '0, '0, got);
        chk("t4 beats_out", popped, 100);

        // Issue while credit is exhausted
        do_reset();
        for (int c = 0; c < 12; c++) cycle(1, 1, 0, 0, rnd(), '0, got);
        chk("t5 allow_low", up_allow, 0);
        chk("t5 err_clean", err, 0);
        cycle(1, 0, 0, 0, rnd(), '0, got);
        chk("t5 err_set", err, 1);
        for (int c = 0; c < 15; c++) cycle(0, 1, 0, 1, '0, '0, got);
        chk("t5 err_sticky", err, 1);

        // Unsolicited arrival right after reset
        do_reset();
        cycle(0, 1, 1, 0, '0, WIDTH'(32'h55), got);
        chk("t5b err", err, 1);
        chk("t5b count", count, 1);

        // Asynchronous reset mid-operation
        do_reset();
        for (int c = 0; c < 7; c++) cycle(1, 1, 0, 0, WIDTH'(c), '0, got);
        cycle(0, 1, 0, 0, '0, '0, got);
        chk("t6 count_pre", count, 5);
        chk("t6 inflight_pre", pipe_occ(), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6 count", count, 0);
        chk("t6 out_valid", out_valid, 0);
        chk("t6 out_data", out_data, 0);
        chk("t6 up_allow", up_allow, 1);
        chk("t6 err", err, 0);

        // Randomized legal traffic with varying consumer back-pressure
        do_reset();
        pct = 60;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) begin
                case ($urandom_range(0, 2))
                    0:       pct = 20;
                    1:       pct = 60;
                    default: pct = 95;
                endcase
            end
            cycle($urandom_range(0, 3) != 0, 1, 0, $urandom_range(0, 99) < pct, rnd(), '0, got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
